// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: default widths, opcode map and FSM state encoding.
package alu_pkg;

    localparam int ALU_DW  = 32;
    localparam int ALU_OPW = 3;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_SRL  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, on a tie the one
// not served last wins. grant_o is meaningless when neither input is valid.
module rr_arb2
    import alu_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       grant_o
);

    assign grant_o = (&valid_i) ? ~last_grant_i : valid_i[1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Define ALU_ARB_OPCHK_EN to answer reserved opcode 3'b111 with an error response and no ALU cycle.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DW  = ALU_DW,
    parameter int OPW = ALU_OPW
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [DW-1:0]  rsp0_data,
    output logic           rsp0_err,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [DW-1:0]  rsp1_data,
    output logic           rsp1_err,

    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_r2,
    output logic [DW-1:0]  alu_r3,
    input  logic [DW-1:0]  alu_r1,
    output logic           busy
);

    arb_state_t           state_q;
    logic                 winner_q;
    logic                 last_grant_q;
    logic                 busy_q;
    logic [OPW-1:0]       alu_op_q;
    logic [DW-1:0]        alu_r2_q;
    logic [DW-1:0]        alu_r3_q;
    logic [1:0]           rsp_valid_q;
    logic [1:0]           rsp_err_q;
    logic [1:0][DW-1:0]   rsp_data_q;

    logic [1:0]           req_valid;
    logic [1:0]           rsp_ready;
    logic [1:0][OPW-1:0]  req_op;
    logic [1:0][DW-1:0]   req_a;
    logic [1:0][DW-1:0]   req_b;

    logic                 grant;
    logic                 accept;
    logic                 rsvd_sel;
    logic                 rsp_done;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign req_op    = {req1_op, req0_op};
    assign req_a     = {req1_a, req0_a};
    assign req_b     = {req1_b, req0_b};

    rr_arb2 u_rr_arb2 (
        .valid_i      (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    // Command ready is offered only while IDLE, and only to the arbitration winner.
    assign accept     = (state_q == IDLE) && (|req_valid);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign rsp_done   = (state_q == RESP) && rsp_ready[winner_q];

`ifdef ALU_ARB_OPCHK_EN
    assign rsvd_sel = (req_op[grant] == OPW'(OP_RSVD));
`else
    assign rsvd_sel = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            winner_q     <= 1'b0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
            alu_op_q     <= '0;
            alu_r2_q     <= '0;
            alu_r3_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= '0;
            rsp_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        winner_q <= grant;
                        busy_q   <= 1'b1;
                        if (rsvd_sel) begin
                            // Reserved opcode never reaches the ALU; its inputs keep their old values.
                            rsp_valid_q[grant] <= 1'b1;
                            rsp_data_q[grant]  <= '0;
                            rsp_err_q[grant]   <= 1'b1;
                            state_q            <= RESP;
                        end else begin
                            alu_op_q <= req_op[grant];
                            alu_r2_q <= req_a[grant];
                            alu_r3_q <= req_b[grant];
                            state_q  <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rsp_valid_q[winner_q] <= 1'b1;
                    rsp_data_q[winner_q]  <= alu_r1;
                    rsp_err_q[winner_q]   <= 1'b0;
                    state_q               <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        rsp_valid_q  <= '0;
                        last_grant_q <= winner_q;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_r2     = alu_r2_q;
    assign alu_r3     = alu_r3_q;
    assign busy       = busy_q;
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_data  = rsp_data_q[0];
    assign rsp1_data  = rsp_data_q[1];
    // Without the opcode check these registers never leave zero, so the flags are constant 0.
    assign rsp0_err   = rsp_err_q[0];
    assign rsp1_err   = rsp_err_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table vectors, hand-written corner sequences and randomized
// traffic, all checked every cycle against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int DW  = 32;
    localparam int OPW = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
    logic           req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
    logic [OPW-1:0] req0_op, req1_op, alu_op;
    logic [DW-1:0]  req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
    logic [DW-1:0]  alu_r1, alu_r2, alu_r3;
    logic           busy;

    always #5 clk = ~clk;

    // ALU stub: always adds, whatever the opcode.
    assign alu_r1 = alu_r2 + alu_r3;

    alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .alu_op(alu_op), .alu_r2(alu_r2), .alu_r3(alu_r3), .alu_r1(alu_r1),
        .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: at most one transaction in flight; it becomes visible a fixed
    // number of cycles after acceptance and retires on the response handshake.
    int          cyc;
    bit          m_busy;
    int          m_who, m_acc_cyc, m_lat, m_last;
    logic [31:0] m_res;
    bit          m_err;
    logic [31:0] m_data [2];
    bit          m_errv [2];
    logic [2:0]  m_aop;
    logic [31:0] m_ar2, m_ar3;

    int          grants[$];
    logic [31:0] got_data [2];
    logic        got_err [2];
    bit          acc0, acc1;

    task automatic model_reset();
        m_busy    = 0;
        m_last    = 1;
        m_data[0] = '0;
        m_data[1] = '0;
        m_errv[0] = 0;
        m_errv[1] = 0;
        m_aop     = '0;
        m_ar2     = '0;
        m_ar3     = '0;
    endtask

    task automatic step();
        bit          vis, rsvd;
        int          win;
        logic [2:0]  op;
        logic [31:0] a, b;
        vis = m_busy && (cyc >= m_acc_cyc + m_lat);
        if (vis && cyc == m_acc_cyc + m_lat) begin
            m_data[m_who] = m_res;
            m_errv[m_who] = m_err;
        end
        chk("busy", busy, m_busy);
        chk("rsp0_valid", rsp0_valid, vis && m_who == 0);
        chk("rsp1_valid", rsp1_valid, vis && m_who == 1);
        chk("rsp0_data", rsp0_data, m_data[0]);
        chk("rsp1_data", rsp1_data, m_data[1]);
        chk("rsp0_err", rsp0_err, m_errv[0]);
        chk("rsp1_err", rsp1_err, m_errv[1]);
        chk("alu_op", alu_op, m_aop);
        chk("alu_r2", alu_r2, m_ar2);
        chk("alu_r3", alu_r3, m_ar3);
        win = -1;
        if (!m_busy) begin
            if (req0_valid && req1_valid) win = 1 - m_last;
            else if (req0_valid)          win = 0;
            else if (req1_valid)          win = 1;
        end
        chk("req0_ready", req0_ready, win == 0);
        chk("req1_ready", req1_ready, win == 1);
        if (vis && ((m_who == 0 && rsp0_ready) || (m_who == 1 && rsp1_ready))) begin
            got_data[m_who] = (m_who == 1) ? rsp1_data : rsp0_data;
            got_err[m_who]  = (m_who == 1) ? rsp1_err : rsp0_err;
            $display("txn cycle %0d: req%0d data=%h err=%0b", cyc, m_who, got_data[m_who], got_err[m_who]);
            m_busy = 0;
            m_last = m_who;
        end else if (win >= 0) begin
            op = (win == 1) ? req1_op : req0_op;
            a  = (win == 1) ? req1_a  : req0_a;
            b  = (win == 1) ? req1_b  : req0_b;
`ifdef ALU_ARB_OPCHK_EN
            rsvd = (op == 3'b111);
`else
            rsvd = 0;
`endif
            m_busy    = 1;
            m_who     = win;
            m_acc_cyc = cyc;
            grants.push_back(win);
            if (rsvd) begin
                m_lat = 1; m_res = '0; m_err = 1;
            end else begin
                m_lat = 2; m_res = a + b; m_err = 0;
                m_aop = op; m_ar2 = a; m_ar3 = b;
            end
        end
        cyc++;
    endtask

    // Inputs are driven at the falling edge; sample() looks #1 later, advance() moves to the next fall.
    task automatic sample();
        #1;
        step();
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
    endtask

    task automatic advance();
        @(negedge clk);
        if (acc0) req0_valid = 0;
        if (acc1) req1_valid = 0;
        acc0 = 0;
        acc1 = 0;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic drain();
        rsp0_ready = 1;
        rsp1_ready = 1;
        for (int k = 0; k < 40 && (req0_valid || req1_valid || m_busy); k++) tick();
        chk("drain idle", {29'd0, req0_valid, req1_valid, m_busy}, 32'd0);
    endtask

    function automatic int gnt(input int i);
        return (i < grants.size()) ? grants[i] : 9;
    endfunction

    typedef struct {
        bit          v0;
        logic [2:0]  op0;
        logic [31:0] a0, b0;
        bit          v1;
        logic [2:0]  op1;
        logic [31:0] a1, b1;
        int          first;
        logic [31:0] d0, d1;
        logic        e0, e1;
    } vec_t;

    vec_t tbl[7];

    task automatic run_rec(input vec_t v, input int idx);
        grants.delete();
        got_data[0] = 32'hdeadbeef; got_data[1] = 32'hdeadbeef;
        got_err[0]  = 1'bx;         got_err[1]  = 1'bx;
        req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
        req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
        drain();
        chk($sformatf("vec%0d first grant", idx), gnt(0), v.first);
        chk($sformatf("vec%0d grant count", idx), grants.size(), v.v0 + v.v1);
        if (v.v0) begin
            chk($sformatf("vec%0d rsp0_data", idx), got_data[0], v.d0);
            chk($sformatf("vec%0d rsp0_err", idx), got_err[0], v.e0);
        end
        if (v.v1) begin
            chk($sformatf("vec%0d rsp1_data", idx), got_data[1], v.d1);
            chk($sformatf("vec%0d rsp1_err", idx), got_err[1], v.e1);
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 3'd0, 32'd1, 32'd2, 1'b1, 3'd0, 32'd10, 32'd20, 0, 32'd3, 32'd30, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 3'd2, 32'h0000ffff, 32'hffff0000, 1'b0, 3'd0, 32'd0, 32'd0, 0, 32'hffffffff, 32'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 3'd4, 32'd7, 32'd8, 1'b1, 3'd5, 32'd100, 32'd200, 1, 32'd15, 32'd300, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 3'd6, 32'hffffffff, 32'd1, 1, 32'd0, 32'd0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 3'd1, 32'h80000000, 32'h80000000, 1'b1, 3'd3, 32'h12345678, 32'h11111111, 0, 32'd0, 32'h23456789, 1'b0, 1'b0};
`ifdef ALU_ARB_OPCHK_EN
        tbl[5] = '{1'b1, 3'd7, 32'd5, 32'd6, 1'b0, 3'd0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 3'd1, 32'd3, 32'd4, 1'b1, 3'd7, 32'h20, 32'h22, 1, 32'd7, 32'd0, 1'b0, 1'b1};
`else
        tbl[5] = '{1'b1, 3'd7, 32'd5, 32'd6, 1'b0, 3'd0, 32'd0, 32'd0, 0, 32'd11, 32'd0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 3'd1, 32'd3, 32'd4, 1'b1, 3'd7, 32'h20, 32'h22, 1, 32'd7, 32'h42, 1'b0, 1'b0};
`endif

        rst_n = 0;
        req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0; rsp0_ready = 0;
        req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0; rsp1_ready = 0;
        acc0 = 0; acc1 = 0; cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset rsp valids", {rsp0_valid, rsp1_valid}, 0);
        chk("reset rsp errs", {rsp0_err, rsp1_err}, 0);
        chk("reset rsp0_data", rsp0_data, 0);
        chk("reset rsp1_data", rsp1_data, 0);
        chk("reset alu regs", {alu_op, alu_r2 | alu_r3}, 0);
        rst_n = 1;

        for (int i = 0; i < 7; i++) run_rec(tbl[i], i);

        // Response back-pressure on requester 1 while requester 0 waits.
        req1_valid = 1; req1_op = 3'd3; req1_a = 32'h1234; req1_b = 32'h1;
        rsp0_ready = 1; rsp1_ready = 0;
        sample(); chk("bp req1_ready", req1_ready, 1); advance();
        req0_valid = 1; req0_op = 3'd0; req0_a = 32'd5; req0_b = 32'd5;
        sample(); chk("bp exec alu_r2", alu_r2, 32'h1234); advance();
        for (int k = 0; k < 5; k++) begin
            sample();
            chk("bp rsp1_valid", rsp1_valid, 1);
            chk("bp rsp1_data", rsp1_data, 32'h1235);
            chk("bp req0_ready", req0_ready, 0);
            advance();
        end
        rsp1_ready = 1;
        tick();
        sample(); chk("bp idle busy", busy, 0); chk("bp req0_ready idle", req0_ready, 1); advance();
        drain();

        // Reset during EXEC: transaction dropped, tie afterwards goes to requester 0.
        req1_valid = 1; req1_op = 3'd2; req1_a = 32'd7; req1_b = 32'd9;
        tick();
        sample(); chk("rst exec alu_r2", alu_r2, 32'd7);
        #1 rst_n = 0; req1_valid = 0;
        #1;
        chk("rst busy", busy, 0);
        chk("rst rsp valids", {rsp0_valid, rsp1_valid}, 0);
        chk("rst alu_r2", alu_r2, 0);
        chk("rst rsp1_data", rsp1_data, 0);
        model_reset();
        acc0 = 0; acc1 = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 3; k++) tick();
        req0_valid = 1; req0_op = 3'd0; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1; req1_op = 3'd0; req1_a = 32'd2; req1_b = 32'd2;
        sample(); chk("rst tie req0_ready", req0_ready, 1); chk("rst tie req1_ready", req1_ready, 0); advance();
        drain();

        // Both requesters keep valid asserted: grants must alternate.
        grants.delete();
        req0_valid = 1; req1_valid = 1;
        for (int k = 0; k < 40 && grants.size() < 4; k++) begin
            tick();
            if (!req0_valid) begin req0_valid = 1; req0_a = $urandom; req0_b = $urandom; end
            if (!req1_valid) begin req1_valid = 1; req1_a = $urandom; req1_b = $urandom; end
        end
        for (int i = 0; i < 4; i++) chk($sformatf("alt grant %0d", i), gnt(i), i % 2);
        drain();

        // Randomized traffic with random response back-pressure.
        for (int k = 0; k < 600; k++) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1; req0_op = 3'($urandom_range(0, 7)); req0_a = $urandom; req0_b = $urandom;
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1; req1_op = 3'($urandom_range(0, 7)); req1_a = $urandom; req1_b = $urandom;
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
